// File: rtl/lsu_bus_if.sv
// Single-outstanding req/ack data bus between the load/store unit and memory.
interface lsu_bus_if #(
  parameter int ADDR_W = 32
) ();
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_wdata;
  logic [3:0]        bus_wstrb;
  logic              bus_ack;
  logic [31:0]       bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output bus_ack, bus_rdata
  );
endinterface : lsu_bus_if

// File: rtl/load_store_unit.sv
// Load/store unit: takes one decoded load or store at a time, runs it on the
// req/ack bus, formats load data for writeback and stalls the core meanwhile.
// Misaligned, illegal and timed-out accesses complete with lsu_fault set.
module load_store_unit #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [2:0]        mem_acc_mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              lsu_stall,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              lsu_fault,
  lsu_bus_if.master         bus
);

  localparam logic [2:0] MODE_B  = 3'b000;
  localparam logic [2:0] MODE_H  = 3'b001;
  localparam logic [2:0] MODE_W  = 3'b010;
  localparam logic [2:0] MODE_BU = 3'b011;
  localparam logic [2:0] MODE_HU = 3'b100;

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            r_state;
  state_e            w_next;

  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_mode;
  logic [31:0]       r_sd;
  logic              r_we;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_load_data;
  logic              r_fault;

  logic              w_req;
  logic              w_fault;
  logic              w_timeout;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load_fmt;

  // Request decode and fault classification on the live controller inputs.
  assign w_req   = rd_en | wr_en;
  assign w_fault = (rd_en & wr_en)
                 | (mem_acc_mode inside {3'b101, 3'b110, 3'b111})
                 | (wr_en & ((mem_acc_mode == MODE_BU) | (mem_acc_mode == MODE_HU)))
                 | (((mem_acc_mode == MODE_H) | (mem_acc_mode == MODE_HU)) & addr[0])
                 | ((mem_acc_mode == MODE_W) & (addr[1:0] != 2'b00));

  // Last no-ack REQ cycle before the timeout limit; disabled when the limit is 0.
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (32'(r_cnt) == TIMEOUT_CYCLES - 1);

  // Extract the addressed lane from the read word and extend it.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_load_fmt = '0;
    w_byte     = bus.bus_rdata[{r_addr[1:0], 3'b000} +: 8];
    w_half     = r_addr[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    if (!r_we) begin
      case (r_mode)
        MODE_B:  w_load_fmt = {{24{w_byte[7]}}, w_byte};
        MODE_BU: w_load_fmt = {24'h0, w_byte};
        MODE_H:  w_load_fmt = {{16{w_half[15]}}, w_half};
        MODE_HU: w_load_fmt = {16'h0, w_half};
        MODE_W:  w_load_fmt = bus.bus_rdata;
        default: w_load_fmt = '0;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Access context, timeout counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr      <= '0;
      r_mode      <= '0;
      r_sd        <= '0;
      r_we        <= 1'b0;
      r_cnt       <= '0;
      r_load_data <= '0;
      r_fault     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_req) begin
            r_addr  <= addr;
            r_mode  <= mem_acc_mode;
            r_sd    <= store_data;
            r_we    <= wr_en;
            r_fault <= w_fault;
            if (w_fault) r_load_data <= '0;
          end
        end
        S_REQ: begin
          if (bus.bus_ack) begin
            r_load_data <= w_load_fmt;
            r_fault     <= 1'b0;
          end else if (w_timeout) begin
            r_load_data <= '0;
            r_fault     <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state logic; an ack in the timeout cycle takes precedence.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_req) w_next = w_fault ? S_DONE : S_REQ;
      S_REQ:   if (bus.bus_ack || w_timeout) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state; bus fields are zero outside REQ.
  always_comb begin
    lsu_stall     = ((r_state == S_IDLE) & w_req) | (r_state == S_REQ);
    load_valid    = (r_state == S_DONE);
    lsu_fault     = (r_state == S_DONE) & r_fault;
    load_data     = r_load_data;
    bus.bus_req   = 1'b0;
    bus.bus_we    = 1'b0;
    bus.bus_addr  = '0;
    bus.bus_wdata = '0;
    bus.bus_wstrb = 4'b0000;
    if (r_state == S_REQ) begin
      bus.bus_req  = 1'b1;
      bus.bus_we   = r_we;
      bus.bus_addr = {r_addr[ADDR_W-1:2], 2'b00};
      if (r_we) begin
        case (r_mode)
          MODE_B: begin
            bus.bus_wdata = {4{r_sd[7:0]}};
            bus.bus_wstrb = 4'b0001 << r_addr[1:0];
          end
          MODE_H: begin
            bus.bus_wdata = {2{r_sd[15:0]}};
            bus.bus_wstrb = r_addr[1] ? 4'b1100 : 4'b0011;
          end
          default: begin
            bus.bus_wdata = r_sd;
            bus.bus_wstrb = 4'b1111;
          end
        endcase
      end
    end
  end

endmodule : load_store_unit
